decimal_key_scheduler: RTL and testbench



---
 rtl/decimal_key_pkg.sv | 29 ++
 rtl/rr_key_picker.sv | 38 +++
 rtl/decimal_key_scheduler.sv | 156 +++++++++++++++
 tb/tb_decimal_key_scheduler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decimal_key_pkg.sv
// Shared constants, FSM state type and small index helpers for the keypad-to-BCD front end.
// Latency: none (package only).
// Backpressure: n/a.
package decimal_key_pkg;

    localparam int NUM_KEYS = 10;
    localparam int BCD_W    = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Round-robin successor of a digit index, wrapping 9 -> 0.
    function automatic logic [BCD_W-1:0] next_idx(input logic [BCD_W-1:0] i);
        return (i == BCD_W'(NUM_KEYS - 1)) ? '0 : i + BCD_W'(1);
    endfunction

    // One-hot key vector for a digit index; indices above 9 map to all-zero.
    function automatic logic [NUM_KEYS-1:0] onehot(input logic [BCD_W-1:0] i);
        logic [NUM_KEYS-1:0] oh;
        oh = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            oh[k] = (i == BCD_W'(k));
        end
        return oh;
    endfunction

endpackage

// File: rtl/rr_key_picker.sv
// Round-robin first-one search over the pending key vector, starting at ptr and wrapping 9 -> 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to take the result.
// Ports: req = pending keys, ptr = search start (0..9), any = some request set, index = winning digit.
module rr_key_picker
    import decimal_key_pkg::*;
(
    input  logic [NUM_KEYS-1:0] req,
    input  logic [BCD_W-1:0]    ptr,
    output logic                any,
    output logic [BCD_W-1:0]    index
);

    logic             found;
    logic [BCD_W-1:0] pos;
    int               p;

    always_comb begin
        any   = |req;
        index = '0;
        found = 1'b0;
        pos   = '0;
        p     = 0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            // Modular offset from ptr keeps the result inside 0..9.
            p = int'(ptr) + i;
            if (p >= NUM_KEYS) begin
                p = p - NUM_KEYS;
            end
            pos = BCD_W'(p);
            if (!found && req[pos]) begin
                found = 1'b1;
                index = pos;
            end
        end
    end

endmodule

// File: rtl/decimal_key_scheduler.sv
// Synchronises and debounces a 10-line keypad, latches each new press as pending, serialises via round robin.
// Latency: DEBOUNCE_CYCLES+3 edges to pending, bcd_valid one edge later; at most one digit per 2 cycles.
// Backpressure: bcd_out/bcd_valid held while bcd_ready=0; further presses accumulate in pending.
// Ports: clk/rst_n, key_in raw keys, bcd_out/bcd_valid/bcd_ready digit handshake,
//        pending = latched undelivered presses, overrun = sticky re-press of a pending key.
module decimal_key_scheduler
    import decimal_key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [BCD_W-1:0]    bcd_out,
    output logic                bcd_valid,
    input  logic                bcd_ready,
    output logic [NUM_KEYS-1:0] pending,
    output logic                overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Input synchroniser and debounce state.
    logic [NUM_KEYS-1:0] s1, s2;
    logic [NUM_KEYS-1:0] cand;
    logic [NUM_KEYS-1:0] stable;
    logic [CNT_W-1:0]    cnt;

    // Request bookkeeping.
    logic [NUM_KEYS-1:0] pending_q, pending_nxt;
    logic                overrun_q, overrun_nxt;
    logic                commit;
    logic [NUM_KEYS-1:0] press;
    logic [NUM_KEYS-1:0] clr;
    logic                hs;

    // Grant FSM.
    state_t              state, state_nxt;
    logic [BCD_W-1:0]    ptr, ptr_nxt;
    logic [BCD_W-1:0]    out_q, out_nxt;
    logic                vld_q, vld_nxt;
    logic                pick_any;
    logic [BCD_W-1:0]    pick_idx;

    // ------------------------------------------------------------------
    // Two-flop synchroniser followed by the debounce counter. The counter
    // saturates at CNT_MAX, so a held vector re-commits every cycle; that is
    // harmless because press only sees 0->1 changes against stable.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= '0;
            s2     <= '0;
            cand   <= '0;
            stable <= '0;
            cnt    <= '0;
        end else begin
            s1 <= key_in;
            s2 <= s1;
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= cand;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign commit = (s2 == cand) && (cnt == CNT_MAX);
    assign press  = commit ? (cand & ~stable) : '0;

    // A digit completes when the consumer takes it; its pending bit clears.
    assign hs  = vld_q & bcd_ready;
    assign clr = hs ? onehot(out_q) : '0;

    // Press is ORed in after the clear, so a same-cycle press on the bit
    // being delivered keeps it pending and is not counted as an overrun.
    always_comb begin
        pending_nxt = (pending_q & ~clr) | press;
        overrun_nxt = overrun_q | (|(press & pending_q & ~clr));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            pending_q <= pending_nxt;
            overrun_q <= overrun_nxt;
        end
    end

    rr_key_picker u_picker (
        .req   (pending_q),
        .ptr   (ptr),
        .any   (pick_any),
        .index (pick_idx)
    );

    // ------------------------------------------------------------------
    // Grant FSM: IDLE picks from the registered pending vector, SEND holds
    // the digit until accepted. Returning through IDLE gives the cleared
    // pending bit a cycle to land before the next pick.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        out_nxt   = out_q;
        vld_nxt   = vld_q;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    out_nxt   = pick_idx;
                    vld_nxt   = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (bcd_ready) begin
                    ptr_nxt   = next_idx(out_q);
                    out_nxt   = '0;
                    vld_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                out_nxt   = '0;
                vld_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            out_q <= '0;
            vld_q <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            out_q <= out_nxt;
            vld_q <= vld_nxt;
        end
    end

    assign bcd_out   = out_q;
    assign bcd_valid = vld_q;
    assign pending   = pending_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_decimal_key_scheduler.sv
// Self-checking bench for decimal_key_scheduler: directed scenarios plus randomized keypad/ready traffic.
// Latency: n/a (testbench).
// Backpressure: bcd_ready driven directly by the bench.
module tb_decimal_key_scheduler;

    localparam int D = 4;

    logic       clk;
    logic       rst_n;
    logic [9:0] key_in;
    logic [3:0] bcd_out;
    logic       bcd_valid;
    logic       bcd_ready;
    logic [9:0] pending;
    logic       overrun;

    decimal_key_scheduler #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .bcd_out   (bcd_out),
        .bcd_valid (bcd_valid),
        .bcd_ready (bcd_ready),
        .pending   (pending),
        .overrun   (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n_tests = 0;
    int n_fail  = 0;
    int vcount  = 0;
    int got[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. A vector is accepted once the synchronised input has
    // held the same value on D+1 consecutive sampling edges; accepted 0->1
    // changes become pending requests; digits are granted one at a time in
    // round-robin order and each grant waits in its own cycle for ready.
    // ------------------------------------------------------------------
    logic [9:0] m_s1, m_s2, m_prev, m_stable, m_pend;
    int         m_run;
    logic       m_ovr, m_vld;
    int         m_out, m_ptr;

    function automatic int rr_pick(input logic [9:0] req, input int start);
        for (int i = 0; i < 10; i++) begin
            if (req[(start + i) % 10]) return (start + i) % 10;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_prev = '0; m_run = 1;
        m_stable = '0; m_pend = '0; m_ovr = 1'b0;
        m_vld = 1'b0; m_out = 0; m_ptr = 0;
    endtask

    task automatic model_step();
        logic [9:0] s2pre, clr, press, pend_old;
        if (!rst_n) begin
            model_reset();
            return;
        end
        s2pre = m_s2;
        m_s2  = m_s1;
        m_s1  = key_in;
        if (s2pre == m_prev) m_run++;
        else begin
            m_run  = 1;
            m_prev = s2pre;
        end
        clr   = (m_vld && bcd_ready) ? (10'd1 << m_out) : 10'd0;
        press = (m_run >= D + 1) ? (s2pre & ~m_stable) : 10'd0;
        if (m_run >= D + 1) m_stable = s2pre;
        if ((press & m_pend & ~clr) != 0) m_ovr = 1'b1;
        pend_old = m_pend;
        m_pend   = (m_pend & ~clr) | press;
        if (m_vld) begin
            if (bcd_ready) begin
                m_vld = 1'b0;
                m_ptr = (m_out + 1) % 10;
                m_out = 0;
            end
        end else if (pend_old != 0) begin
            m_out = rr_pick(pend_old, m_ptr);
            m_vld = 1'b1;
        end
    endtask

    // One clock: log any handshake about to happen, advance the model on the
    // rising edge, compare all outputs on the falling edge.
    task automatic tick();
        if (rst_n && bcd_valid && bcd_ready) got.push_back(int'(bcd_out));
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (bcd_valid) vcount++;
        check_eq("bcd_valid", bcd_valid, m_vld);
        check_eq("bcd_out",   bcd_out,   m_out);
        check_eq("pending",   pending,   m_pend);
        check_eq("overrun",   overrun,   m_ovr);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_vld(input string tag, input int budget);
        int k;
        k = 0;
        while (!bcd_valid && k < budget) begin
            tick();
            k++;
        end
        if (!bcd_valid) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int first;
        int hold;
        logic [9:0] rk;

        rst_n = 1'b0; key_in = '0; bcd_ready = 1'b0;
        model_reset();
        #1;
        check_eq("rst_valid",   bcd_valid, 0);
        check_eq("rst_out",     bcd_out,   0);
        check_eq("rst_pending", pending,   0);
        check_eq("rst_overrun", overrun,   0);
        run(3);
        rst_n = 1'b1;
        run(2);

        // 1: single key 0, ready high; valid first seen after edge 8, one cycle wide.
        got.delete(); vcount = 0; first = 0;
        key_in = 10'b0000000001; bcd_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bcd_valid && first == 0) first = i;
        end
        check_eq("t1_latency", first, 8);
        check_eq("t1_vcount",  vcount, 1);
        check_eq("t1_ndig",    got.size(), 1);
        if (got.size() > 0) check_eq("t1_digit", got[0], 0);
        check_eq("t1_pending", pending, 0);
        check_eq("t1_overrun", overrun, 0);
        key_in = '0;
        run(10);

        // 2: key 9 stalled for 5 cycles, then accepted once.
        got.delete();
        key_in = 10'b1000000000; bcd_ready = 1'b0;
        wait_vld("t2", 20);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("t2_hold_out", bcd_out, 9);
            check_eq("t2_hold_vld", bcd_valid, 1);
        end
        bcd_ready = 1'b1;
        run(6);
        check_eq("t2_ndig", got.size(), 1);
        if (got.size() > 0) check_eq("t2_digit", got[0], 9);
        key_in = '0;
        run(10);

        // 3: fresh reset, keys 1 and 3 together -> 1 then 3.
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        got.delete();
        key_in = 10'b0000001010;
        run(20);
        check_eq("t3_ndig", got.size(), 2);
        if (got.size() == 2) begin
            check_eq("t3_first",  got[0], 1);
            check_eq("t3_second", got[1], 3);
        end
        key_in = '0;
        run(10);

        // 4: deliver key 5, then keys 9 and 0 together -> 9 then 0 (wrap).
        got.delete();
        key_in = 10'b0000100000;
        run(15);
        key_in = '0;
        run(10);
        key_in = 10'b1000000001;
        run(20);
        check_eq("t4_ndig", got.size(), 3);
        if (got.size() == 3) begin
            check_eq("t4_d0", got[0], 5);
            check_eq("t4_d1", got[1], 9);
            check_eq("t4_d2", got[2], 0);
        end
        key_in = '0;
        run(10);

        // 5: bit 4 bouncing every 2 cycles never settles -> nothing delivered.
        vcount = 0;
        for (int i = 0; i < 6; i++) begin
            key_in = (i % 2 == 0) ? 10'b0000010000 : 10'b0;
            run(2);
        end
        key_in = '0;
        run(12);
        check_eq("t5_vcount",  vcount, 0);
        check_eq("t5_pending", pending, 0);

        // 6: press/release/press key 5 while stalled -> overrun, single digit 5.
        got.delete();
        bcd_ready = 1'b0;
        key_in = 10'b0000100000; run(10);
        key_in = '0;             run(10);
        key_in = 10'b0000100000; run(10);
        check_eq("t6_overrun", overrun, 1);
        bcd_ready = 1'b1;
        run(8);
        check_eq("t6_ndig", got.size(), 1);
        if (got.size() > 0) check_eq("t6_digit", got[0], 5);
        key_in = '0;
        run(10);
        // Async reset during a later SEND.
        bcd_ready = 1'b0;
        key_in = 10'b0000000100;
        wait_vld("t6b", 20);
        run(2);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_vld",  bcd_valid, 0);
        check_eq("t6_rst_pend", pending,   0);
        check_eq("t6_rst_ovr",  overrun,   0);
        model_reset();
        @(negedge clk);
        key_in = '0;
        run(2);
        rst_n = 1'b1;
        run(3);

        // Random traffic: mostly single keys, some multi-hot, random hold lengths and ready.
        for (int s = 0; s < 250; s++) begin
            case ($urandom_range(0, 3))
                0:       rk = '0;
                1, 2:    rk = 10'd1 << $urandom_range(0, 9);
                default: rk = 10'($urandom_range(0, 1023));
            endcase
            key_in = rk;
            hold = $urandom_range(1, 12);
            for (int c = 0; c < hold; c++) begin
                bcd_ready = ($urandom_range(0, 2) != 0);
                tick();
            end
        end
        key_in = '0;
        bcd_ready = 1'b1;
        run(40);
        check_eq("end_pending", pending, 0);
        check_eq("end_valid",   bcd_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
